multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Sequencing controller for the multicycle MIPS datapath. Decodes opcode/funct as the single-cycle Control unit does, but
//  issues per-state control strobes over several cycles and shares one memory port between instruction fetch and lw/sw.
//  Memory is accessed with a req/ready handshake; a watchdog flags a memory port that never answers.
// PARAMETERS
//  MEM_TIMEOUT   16   cycles waiting for mem_ready before mem_timeout is pulsed and the FSM returns to FETCH
// PORTS
//  clk           in   1  single clock, all state on rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  opcode        in   6  instr[31:26], sampled from IR (valid from DECODE onward)
//  funct         in   6  instr[5:0]
//  mem_ready     in   1  memory completes current access this cycle
//  mem_req       out  1  memory access request (held until mem_ready)
//  IorD          out  1  0=PC address, 1=ALUOut address
//  MemWrite      out  1  store strobe (qualifies mem_req)
//  IRWrite       out  1  load IR on fetch completion
//  PCWrite       out  1  unconditional PC write
//  Beq, Bne      out  1  conditional PC write enables (datapath ANDs with Zero / ~Zero)
//  PCSrc         out  2  00 ALU, 01 ALUOut, 10 jump target
//  ALUSrcA       out  1  0=PC, 1=reg A
//  ALUSrcB       out  2  00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  ALUControl    out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  RegDst        out  1  1=rd, 0=rt
//  MemToReg      out  1  1=MDR to register file
//  RegWrite      out  1  register file write
//  illegal_op    out  1  one-cycle pulse in DECODE on unsupported opcode/funct
//  mem_timeout   out  1  one-cycle pulse when watchdog expires
// BEHAVIOUR
//  - Reset: state=FETCH, watchdog=0; all outputs 0 except those FETCH drives combinationally (Moore, from state only).
//  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010. On mem_ready: IRWrite=1, PCWrite=1, PCSrc=00
//    (PC<=PC+4), -> DECODE. Without mem_ready stay; IRWrite/PCWrite only in the mem_ready cycle (Mealy on mem_ready).
//  - DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target to ALUOut). Next: lw/sw->MEMADR, R-type->EXEC, beq/bne->BRANCH,
//    j->JUMP; any other opcode or R-type funct not in {100000,100010,100100,100101,101010}: illegal_op=1, ->FETCH.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, add. lw->MEMRD, sw->MEMWR.
//  - MEMRD: mem_req=1, IorD=1; on mem_ready -> MEMWB. MEMWB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
//  - MEMWR: mem_req=1, IorD=1, MemWrite=1; on mem_ready -> FETCH.
//  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from funct -> ALUWB. ALUWB: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Beq=1 (beq) or Bne=1 (bne) -> FETCH.
//  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
//  - Cycles excl. memory wait: j/beq/bne 3, R-type 4, sw 4, lw 5; each memory state adds its wait cycles.
//  - opcode/funct are latched into internal regs in DECODE; later states use the latched copy (IR may change).
//  - Watchdog: counts cycles with mem_req=1 & mem_ready=0, clears on mem_ready or state change. Reaching MEM_TIMEOUT:
//    mem_timeout=1, no IRWrite/PCWrite/RegWrite, -> FETCH, counter cleared. MEM_TIMEOUT=1 times out on first wait cycle.
//  - mem_ready while mem_req=0 is ignored. Unused strobes are 0 in every state (never x).
//  - rst_n low mid-instruction: immediate return to FETCH, strobes drop asynchronously; no partial write completes.
// STRUCTURE
//  - Package mips_ctrl_pkg: state enum, opcode constants (RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101,
//    J 000010), funct constants, ALUControl encodings, ALUSrcB/PCSrc encodings; shared with the single-cycle Control.
//  - Sub-module alu_decoder (funct + op class -> ALUControl, funct_valid); state register, next-state, outputs here.
// TESTING
//  - Reset held, release; mem_ready=1 always: FETCH cycle shows mem_req=1, IorD=0, IRWrite=1, PCWrite=1, ALUSrcB=01.
//  - add (000000/100000), mem_ready=1: FETCH,DECODE,EXEC(ALUControl=010),ALUWB(RegWrite=1,RegDst=1); 4 cycles.
//  - lw with mem_ready delayed 2 cycles in MEMRD: 7 cycles total; MEMWB asserts MemToReg=1, RegWrite=1, RegDst=0.
//  - sw then beq then bne then j: MemWrite only in MEMWR; Beq=1/Bne=1 in BRANCH with ALUControl=110; PCSrc=10 in JUMP.
//  - opcode 111111 and R-type funct 000000: illegal_op pulses once in DECODE, next state FETCH, no RegWrite.
//  - mem_ready stuck 0 in FETCH, MEM_TIMEOUT=16: mem_timeout pulses at 16th wait cycle, no IRWrite; rst_n low mid-MEMWR
//    drops MemWrite immediately and restarts in FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the MIPS control units: FSM state
//               encoding, opcode/funct values, ALU and mux select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Multicycle sequencer states (explicit 4-bit encoding)
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_t;

    // Operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    // ALUSrcB selects
    localparam logic [1:0] c_srcb_regb    = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sl2 = 2'b11;

    // PCSrc selects
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // True for the two instructions that go through the memory address state
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == c_op_lw) || (op == c_op_sw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps operation class and R-type funct to ALUControl, and
//               flags whether the funct field is a supported operation.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    input  aluop_t     i_aluop,
    output logic [2:0] o_alu_control,
    output logic       o_funct_valid
);

    logic [2:0] w_fn_ctrl;

    // Decode the funct field; unsupported codes fall back to add and are flagged
    always_comb begin
        w_fn_ctrl     = c_alu_add;
        o_funct_valid = 1'b1;
        case (i_funct)
            c_fn_add: w_fn_ctrl = c_alu_add;
            c_fn_sub: w_fn_ctrl = c_alu_sub;
            c_fn_and: w_fn_ctrl = c_alu_and;
            c_fn_or:  w_fn_ctrl = c_alu_or;
            c_fn_slt: w_fn_ctrl = c_alu_slt;
            default: begin
                w_fn_ctrl     = c_alu_add;
                o_funct_valid = 1'b0;
            end
        endcase
    end

    // Select the final ALU operation from the requested class
    always_comb begin
        o_alu_control = c_alu_add;
        case (i_aluop)
            ALUOP_ADD:   o_alu_control = c_alu_add;
            ALUOP_SUB:   o_alu_control = c_alu_sub;
            ALUOP_FUNCT: o_alu_control = w_fn_ctrl;
            default:     o_alu_control = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle MIPS sequencer. Issues per-state datapath strobes,
//               shares one req/ready memory port between fetch and lw/sw,
//               and aborts to FETCH when the memory port stops answering.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Beq,
    output logic       Bne,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int                c_wd_w    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [c_wd_w-1:0] r_wd;
    logic              w_mem_req;
    logic              w_timeout;
    logic              w_op_legal;
    logic              w_illegal;
    logic [5:0]        w_dec_funct;
    aluop_t            w_aluop;
    logic [2:0]        w_alu_ctrl;
    logic              w_funct_valid;

    // The IR is only guaranteed stable in DECODE; afterwards use the latched copy
    assign w_dec_funct = (r_state == ST_DECODE) ? funct : r_funct;

    alu_decoder u_alu_decoder (
        .i_funct       (w_dec_funct),
        .i_aluop       (w_aluop),
        .o_alu_control (w_alu_ctrl),
        .o_funct_valid (w_funct_valid)
    );

    assign w_mem_req  = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
    assign w_timeout  = w_mem_req && !mem_ready && (r_wd == c_wd_last);
    assign w_op_legal = is_mem_op(opcode) || (opcode == c_op_beq) || (opcode == c_op_bne) ||
                        (opcode == c_op_j) || ((opcode == c_op_rtype) && w_funct_valid);
    assign w_illegal  = (r_state == ST_DECODE) && !w_op_legal;

    assign mem_req     = w_mem_req;
    assign mem_timeout = w_timeout;
    assign illegal_op  = w_illegal;
    assign ALUControl  = w_alu_ctrl;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture opcode/funct in DECODE so later states survive IR changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
        end else if (r_state == ST_DECODE) begin
            r_opcode <= opcode;
            r_funct  <= funct;
        end
    end

    // Watchdog: count unanswered request cycles, restart on any progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (w_timeout || mem_ready || (w_next_state != r_state)) begin
            r_wd <= '0;
        end else if (w_mem_req) begin
            r_wd <= r_wd + c_wd_w'(1);
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_timeout) begin
                    w_next_state = ST_FETCH;
                end else if (mem_ready) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!w_op_legal) begin
                    w_next_state = ST_FETCH;
                end else if (is_mem_op(opcode)) begin
                    w_next_state = ST_MEMADR;
                end else if (opcode == c_op_rtype) begin
                    w_next_state = ST_EXEC;
                end else if ((opcode == c_op_beq) || (opcode == c_op_bne)) begin
                    w_next_state = ST_BRANCH;
                end else begin
                    w_next_state = ST_JUMP;
                end
            end
            ST_MEMADR: w_next_state = (r_opcode == c_op_lw) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (w_timeout) begin
                    w_next_state = ST_FETCH;
                end else if (mem_ready) begin
                    w_next_state = ST_MEMWB;
                end
            end
            ST_MEMWR: begin
                if (w_timeout || mem_ready) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_EXEC:   w_next_state = ST_ALUWB;
            ST_MEMWB,
            ST_ALUWB,
            ST_BRANCH,
            ST_JUMP:   w_next_state = ST_FETCH;
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // Output logic: Moore per state, plus fetch-completion strobes on mem_ready
    always_comb begin
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Beq      = 1'b0;
        Bne      = 1'b0;
        PCSrc    = c_pcsrc_alu;
        ALUSrcA  = 1'b0;
        ALUSrcB  = c_srcb_regb;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        w_aluop  = ALUOP_ADD;
        case (r_state)
            ST_FETCH: begin
                ALUSrcB = c_srcb_four;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            ST_DECODE: begin
                ALUSrcB = c_srcb_imm_sl2;
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_imm;
            end
            ST_MEMRD: begin
                IorD = 1'b1;
            end
            ST_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA = 1'b1;
                w_aluop = ALUOP_SUB;
                PCSrc   = c_pcsrc_aluout;
                Beq     = (r_opcode == c_op_beq);
                Bne     = (r_opcode == c_op_bne);
            end
            ST_JUMP: begin
                PCSrc   = c_pcsrc_jump;
                PCWrite = 1'b1;
            end
            default: begin
                IorD = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Directed self-checking bench for the multicycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, Beq, Bne;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst, MemToReg, RegWrite, illegal_op, mem_timeout;

    int tests  = 0;
    int failed = 0;

    multicycle_control_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Beq        (Beq),
        .Bne        (Bne),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req,IorD,MemWrite,IRWrite,PCWrite,Beq,Bne,PCSrc,ALUSrcA,ALUSrcB,ALUControl,RegDst,MemToReg,RegWrite,illegal_op,mem_timeout}
    logic [19:0] ctl;
    assign ctl = {mem_req, IorD, MemWrite, IRWrite, PCWrite, Beq, Bne, PCSrc, ALUSrcA, ALUSrcB,
                  ALUControl, RegDst, MemToReg, RegWrite, illegal_op, mem_timeout};

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, XX = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100;
    localparam logic [5:0] FOR = 6'b100101, FSLT = 6'b101010;

    // Field masks
    localparam logic [19:0] F_MREQ = 20'h80000, F_IORD = 20'h40000, F_MW = 20'h20000, F_IRW = 20'h10000;
    localparam logic [19:0] F_PCW = 20'h08000, F_BEQ = 20'h04000, F_BNE = 20'h02000, F_PCSRC = 20'h01800;
    localparam logic [19:0] F_SRCA = 20'h00400, F_SRCB = 20'h00300, F_ALUC = 20'h000E0, F_REGDST = 20'h00010;
    localparam logic [19:0] F_M2R = 20'h00008, F_REGW = 20'h00004, F_ILL = 20'h00002, F_TO = 20'h00001;

    // Strobes are checked in every state; mux selects only where the state defines them
    localparam logic [19:0] M_STB   = F_MREQ | F_MW | F_IRW | F_PCW | F_BEQ | F_BNE | F_REGW | F_ILL | F_TO;
    localparam logic [19:0] M_FETCH = M_STB | F_IORD | F_PCSRC | F_SRCA | F_SRCB | F_ALUC;
    localparam logic [19:0] M_ALU   = M_STB | F_SRCA | F_SRCB | F_ALUC;
    localparam logic [19:0] M_MEM   = M_STB | F_IORD;
    localparam logic [19:0] M_WB    = M_STB | F_REGDST | F_M2R;
    localparam logic [19:0] M_BR    = M_STB | F_PCSRC | F_SRCA | F_SRCB | F_ALUC;
    localparam logic [19:0] M_J     = M_STB | F_PCSRC;

    localparam logic [19:0] E_FETCH_W  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_FETCH_R  = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_FETCH_TO = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0,1'b1};
    localparam logic [19:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [19:0] E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_MEMRD    = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_MEMWR    = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b1,1'b1,1'b0,1'b0};
    localparam logic [19:0] E_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0,1'b1,1'b0,1'b0};
    localparam logic [19:0] E_BEQ      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_BNE      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] E_JUMP     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0};

    // EXEC expectation for a given ALUControl value
    function automatic logic [19:0] e_exec(input logic [2:0] aluc);
        return {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,aluc,1'b0,1'b0,1'b0,1'b0,1'b0};
    endfunction

    typedef struct {
        logic        rdy;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [19:0] e;
        logic [19:0] m;
    } step_t;

    function automatic step_t mk(input logic rdy, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [19:0] e, input logic [19:0] m);
        step_t s;
        s.rdy = rdy; s.op = op; s.fn = fn; s.e = e; s.m = m;
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = RT; funct = FADD;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ((ctl & M_FETCH) !== E_FETCH_W) begin
            failed++;
            $display("FAIL reset_hold: got %05h expected %05h", ctl & M_FETCH, E_FETCH_W);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if ((ctl & M_FETCH) !== E_FETCH_W) begin
            failed++;
            $display("FAIL reset_release: got %05h expected %05h", ctl & M_FETCH, E_FETCH_W);
        end
    endtask

    task automatic test_add();
        step_t s[$];
        s.push_back(mk(1'b1, RT, FADD, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, RT, FADD, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, e_exec(3'b010), M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_ALUWB, M_WB));
        foreach (s[i]) begin
            @(negedge clk);
            mem_ready = s[i].rdy; opcode = s[i].op; funct = s[i].fn;
            #1;
            tests++;
            if ((ctl & s[i].m) !== s[i].e) begin
                failed++;
                $display("FAIL add[%0d]: got %05h expected %05h", i, ctl & s[i].m, s[i].e);
            end
        end
    endtask

    task automatic test_rtype_funcs();
        logic [5:0] fns [4]  = '{FSUB, FAND, FOR, FSLT};
        logic [2:0] alus [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
        for (int k = 0; k < 4; k++) begin
            step_t s[$];
            s.push_back(mk(1'b1, RT, fns[k], E_FETCH_R, M_FETCH));
            s.push_back(mk(1'b1, RT, fns[k], E_DECODE, M_ALU));
            s.push_back(mk(1'b1, XX, XX, e_exec(alus[k]), M_ALU));
            s.push_back(mk(1'b1, XX, XX, E_ALUWB, M_WB));
            foreach (s[i]) begin
                @(negedge clk);
                mem_ready = s[i].rdy; opcode = s[i].op; funct = s[i].fn;
                #1;
                tests++;
                if ((ctl & s[i].m) !== s[i].e) begin
                    failed++;
                    $display("FAIL rtype_fn%02h[%0d]: got %05h expected %05h", fns[k], i, ctl & s[i].m, s[i].e);
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        step_t s[$];
        s.push_back(mk(1'b1, LW, XX, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, LW, XX, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_MEMADR, M_ALU));
        s.push_back(mk(1'b0, XX, XX, E_MEMRD, M_MEM));
        s.push_back(mk(1'b0, XX, XX, E_MEMRD, M_MEM));
        s.push_back(mk(1'b1, XX, XX, E_MEMRD, M_MEM));
        s.push_back(mk(1'b1, XX, XX, E_MEMWB, M_WB));
        foreach (s[i]) begin
            @(negedge clk);
            mem_ready = s[i].rdy; opcode = s[i].op; funct = s[i].fn;
            #1;
            tests++;
            if ((ctl & s[i].m) !== s[i].e) begin
                failed++;
                $display("FAIL lw[%0d]: got %05h expected %05h", i, ctl & s[i].m, s[i].e);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        s.push_back(mk(1'b1, SW, XX, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, SW, XX, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_MEMADR, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_MEMWR, M_MEM));
        s.push_back(mk(1'b1, BEQ, XX, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, BEQ, XX, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_BEQ, M_BR));
        s.push_back(mk(1'b1, BNE, XX, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, BNE, XX, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_BNE, M_BR));
        s.push_back(mk(1'b1, J, XX, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, J, XX, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_JUMP, M_J));
        foreach (s[i]) begin
            @(negedge clk);
            mem_ready = s[i].rdy; opcode = s[i].op; funct = s[i].fn;
            #1;
            tests++;
            if ((ctl & s[i].m) !== s[i].e) begin
                failed++;
                $display("FAIL b2b[%0d]: got %05h expected %05h", i, ctl & s[i].m, s[i].e);
            end
        end
    endtask

    task automatic test_illegal();
        step_t s[$];
        s.push_back(mk(1'b1, XX, FADD, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, XX, FADD, E_DEC_ILL, M_ALU));
        s.push_back(mk(1'b1, RT, 6'b000000, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, RT, 6'b000000, E_DEC_ILL, M_ALU));
        foreach (s[i]) begin
            @(negedge clk);
            mem_ready = s[i].rdy; opcode = s[i].op; funct = s[i].fn;
            #1;
            tests++;
            if ((ctl & s[i].m) !== s[i].e) begin
                failed++;
                $display("FAIL illegal[%0d]: got %05h expected %05h", i, ctl & s[i].m, s[i].e);
            end
        end
    endtask

    // Entered straight from DECODE of an illegal op, so the first FETCH wait is wait cycle 1
    task automatic test_timeout();
        step_t s[$];
        for (int k = 0; k < 15; k++) s.push_back(mk(1'b0, XX, XX, E_FETCH_W, M_FETCH));
        s.push_back(mk(1'b0, XX, XX, E_FETCH_TO, M_FETCH));
        s.push_back(mk(1'b0, XX, XX, E_FETCH_W, M_FETCH));
        s.push_back(mk(1'b1, J, XX, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, J, XX, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_JUMP, M_J));
        foreach (s[i]) begin
            @(negedge clk);
            mem_ready = s[i].rdy; opcode = s[i].op; funct = s[i].fn;
            #1;
            tests++;
            if ((ctl & s[i].m) !== s[i].e) begin
                failed++;
                $display("FAIL timeout[%0d]: got %05h expected %05h", i, ctl & s[i].m, s[i].e);
            end
        end
    endtask

    task automatic test_reset_mid_memwr();
        step_t s[$];
        step_t r[$];
        s.push_back(mk(1'b1, SW, XX, E_FETCH_R, M_FETCH));
        s.push_back(mk(1'b1, SW, XX, E_DECODE, M_ALU));
        s.push_back(mk(1'b1, XX, XX, E_MEMADR, M_ALU));
        s.push_back(mk(1'b0, XX, XX, E_MEMWR, M_MEM));
        foreach (s[i]) begin
            @(negedge clk);
            mem_ready = s[i].rdy; opcode = s[i].op; funct = s[i].fn;
            #1;
            tests++;
            if ((ctl & s[i].m) !== s[i].e) begin
                failed++;
                $display("FAIL rst_memwr[%0d]: got %05h expected %05h", i, ctl & s[i].m, s[i].e);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ((ctl & M_FETCH) !== E_FETCH_W) begin
            failed++;
            $display("FAIL rst_async_drop: got %05h expected %05h", ctl & M_FETCH, E_FETCH_W);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r.push_back(mk(1'b1, RT, FADD, E_FETCH_R, M_FETCH));
        r.push_back(mk(1'b1, RT, FADD, E_DECODE, M_ALU));
        r.push_back(mk(1'b1, XX, XX, e_exec(3'b010), M_ALU));
        r.push_back(mk(1'b1, XX, XX, E_ALUWB, M_WB));
        r.push_back(mk(1'b0, XX, XX, E_FETCH_W, M_FETCH));
        foreach (r[i]) begin
            if (i > 0) @(negedge clk);
            mem_ready = r[i].rdy; opcode = r[i].op; funct = r[i].fn;
            #1;
            tests++;
            if ((ctl & r[i].m) !== r[i].e) begin
                failed++;
                $display("FAIL restart[%0d]: got %05h expected %05h", i, ctl & r[i].m, r[i].e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
        test_reset();
        test_add();
        test_rtype_funcs();
        test_lw_wait();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_memwr();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no finish expected finish before 100000");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
